act_stream: RTL

- Parametrised, pipelined activation unit; successor to the single-shot 32-bit ReLU stage.
- Streams LANES signed fixed-point values per beat, with address tag and last flag, through a selectable activation function.
- Uses a valid/ready handshake with full backpressure.
- Sits between the conv/FC accumulator output and the activation buffer write port in the KWS datapath.

---
 rtl/act_pkg.sv | 21 ++
 rtl/act_lane.sv | 44 ++++
 rtl/act_stream.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the act_stream activation pipeline: mode encodings,
// default fixed-point format and the CLIP ceiling helper.
package act_pkg;

  // Default lane format is 1.7.24 signed fixed point.
  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultFracW = 24;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_LEAKY  = 2'd3
  } act_mode_e;

  // Integer ceiling moved into the fixed-point domain; callers truncate to the lane width.
  function automatic longint unsigned clip_ceil(int unsigned clip_int, int unsigned frac_w);
    return longint'(clip_int) << frac_w;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-lane combinational activation: y = f(x) for the selected mode, plus a
// flag telling whether the activation altered the value.
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FRAC_W     = DefaultFracW,
  parameter int unsigned CLIP_INT   = 6,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  act_mode_e                mode_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     changed_o
);

  localparam logic signed [DATA_W-1:0] Ceil = DATA_W'(clip_ceil(CLIP_INT, FRAC_W));
  // Signed zero so every comparison below stays signed.
  localparam logic signed [DATA_W-1:0] Zero = '0;

  // Per-mode activation; LEAKY uses an arithmetic shift so negatives round toward -inf.
  always_comb begin
    y_o = x_i;
    unique case (mode_i)
      ACT_BYPASS: y_o = x_i;
      ACT_RELU: begin
        if (x_i <= Zero) y_o = Zero;
      end
      ACT_CLIP: begin
        if (x_i <= Zero) begin
          y_o = Zero;
        end else if (x_i >= Ceil) begin
          y_o = Ceil;
        end
      end
      ACT_LEAKY: begin
        if (x_i < Zero) y_o = x_i >>> LEAK_SHIFT;
      end
      default: y_o = x_i;
    endcase
    changed_o = (y_o != x_i);
  end

endmodule

// File: rtl/act_stream.sv
// act_stream: two-stage valid/ready activation pipeline. S1 registers the
// incoming beat and its mode, S2 registers the activated result. Full
// backpressure, one beat per cycle, two cycles of latency.
// Optional lane-change statistics output clip_cnt when ACT_STREAM_STATS_EN is defined.
module act_stream
  import act_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FRAC_W     = DefaultFracW,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LANES      = 1,
  parameter int unsigned CLIP_INT   = 6,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               act_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*DATA_W-1:0]  out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_last,
  output logic                     busy
`ifdef ACT_STREAM_STATS_EN
  ,
  output logic [15:0]              clip_cnt
`endif
);

  localparam int unsigned BeatW = LANES * DATA_W;

  logic             s1_valid_q, s1_valid_d;
  logic [BeatW-1:0] s1_data_q, s1_data_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic             s1_last_q, s1_last_d;
  act_mode_e        s1_mode_q, s1_mode_d;

  logic             s2_valid_q, s2_valid_d;
  logic [BeatW-1:0] s2_data_q, s2_data_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic             s2_last_q, s2_last_d;

  logic             s1_adv, s2_adv;
  logic [BeatW-1:0] act_data;
  logic [LANES-1:0] lane_chg;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_W     (DATA_W),
      .FRAC_W     (FRAC_W),
      .CLIP_INT   (CLIP_INT),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x_i       (s1_data_q[i*DATA_W +: DATA_W]),
      .mode_i    (s1_mode_q),
      .y_o       (act_data[i*DATA_W +: DATA_W]),
      .changed_o (lane_chg[i])
    );
  end

  // Stage advance and next-state for both pipeline stages.
  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_addr_d  = s2_addr_q;
    s2_last_d  = s2_last_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_addr_d = in_addr;
        s1_last_d = in_last;
        s1_mode_d = act_mode_e'(act_mode);
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = act_data;
        s2_addr_d = s1_addr_q;
        s2_last_d = s1_last_q;
      end
    end
  end

`ifdef ACT_STREAM_STATS_EN
  localparam int unsigned CntW = $clog2(LANES + 1);

  logic [CntW-1:0] beat_chg;
  logic [CntW-1:0] s2_chg_q, s2_chg_d;
  logic [15:0]     clip_cnt_q, clip_cnt_d;
  logic            clr_q, clr_d;
  logic [16:0]     cnt_sum;

  // Count changed lanes per beat; accumulate on delivery, clear the cycle after a last beat.
  always_comb begin
    beat_chg = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      beat_chg = beat_chg + CntW'(lane_chg[i]);
    end
    s2_chg_d = s2_chg_q;
    if (s2_adv && s1_valid_q) s2_chg_d = beat_chg;

    cnt_sum = clr_q ? 17'd0 : {1'b0, clip_cnt_q};
    if (s2_valid_q && out_ready) cnt_sum = cnt_sum + 17'(s2_chg_q);
    clip_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    clr_d      = s2_valid_q && out_ready && s2_last_q;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_chg_q   <= '0;
      clip_cnt_q <= '0;
      clr_q      <= 1'b0;
    end else begin
      s2_chg_q   <= s2_chg_d;
      clip_cnt_q <= clip_cnt_d;
      clr_q      <= clr_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`else
  logic unused_chg;
  assign unused_chg = ^lane_chg;
`endif

  // Pipeline registers; synchronous reset discards any in-flight beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= ACT_BYPASS;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      s1_last_q  <= s1_last_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_addr_q  <= s2_addr_d;
      s2_last_q  <= s2_last_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_addr  = s2_addr_q;
  assign out_last  = s2_last_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule
